// File: rtl/jkff_bank.sv
// jkff_bank: WIDTH-bit bank of JK/D/T flip-flops or up/down counter with sticky SR-violation flag
module jkff_bank #(
    parameter int WIDTH = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    output logic             sr_err,
    output logic             tc
);
    logic [WIDTH-1:0] nxt;
    always_comb begin
        nxt = mode == 2'b00 ? (j & ~x) | (~k & x) :
              mode == 2'b01 ? j :
              mode == 2'b10 ? x ^ j :
              k[0]          ? x - 1'b1 : x + 1'b1;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x      <= RESET_VAL;
            sr_err <= 1'b0;
        end else if (en) begin
            x <= nxt;
            if (mode == 2'b00 && |(j & k)) sr_err <= 1'b1;
        end
    end
    assign y  = ~x;
    assign tc = en && mode == 2'b11 && (k[0] ? x == '0 : x == '1);
endmodule

// File: doc/jkff_bank.md
# jkff_bank

Parametrised bank of WIDTH edge-triggered flip-flops sharing one clock and one asynchronous reset. Each bit behaves as a JK flip-flop by default. A shared mode select reconfigures the whole bank as D, T or SR flip-flops, or as a binary up/down counter. It is the general-purpose storage and counting element for control paths that previously instantiated single-bit JK cells one by one.

## Interface
- WIDTH, 8, number of flip-flops in the bank (≥ 2)
- RESET_VAL, {WIDTH{1'b0}}, value loaded into x on reset
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  update enable; 0 = every bit holds
- mode  in  2  00 JK, 01 D, 10 T, 11 COUNT
- j  in  WIDTH  per-bit J / D / T / S input, depending on mode
- k  in  WIDTH  per-bit K / R input; k[0] = count direction in COUNT mode
- x  out  WIDTH  flip-flop state (Q)
- y  out  WIDTH  complement state, always exactly ~x
- sr_err  out  1  sticky flag: a forbidden S=R=1 was presented in SR use
- tc  out  1  terminal count indicator, COUNT mode only

## Operation
- Reset (rst=1): x=RESET_VAL, y=~RESET_VAL, sr_err=0, immediately and independently of clk. Reset dominates en and mode.
- Reset mid-operation discards the in-flight update; the first edge after rst deasserts applies the normal mode rules.
- en=0: x holds on every edge in every mode. sr_err holds.
- Per-bit rules on a rising edge with en=1, where q is the current bit:
  - JK (00): 00 hold, 10 set, 01 clear, 11 toggle.
  - D (01): q ← j[i]. k is ignored.
  - T (10): q ← q ^ j[i]. k is ignored.
- SR variant: selected by mode=00 when the per-bit pair is used as S/R.
  - The bank flags j[i]&k[i] in JK mode as an SR violation only when the parameter-free sr_chk behaviour applies, i.e. in mode 00 itself. JK toggle still takes place.
  - sr_err sets on any edge with en=1, mode=00 and |(j&k)=1 while sr_chk is tied high.
  - Resolved for this revision: there is no sr_chk port. sr_err sets on any edge with en=1, mode=00 and any j[i]=k[i]=1, and the toggle is still performed.
  - sr_err is cleared only by rst.
- COUNT (11): x ← x+1 when k[0]=0, x ← x−1 when k[0]=1. j is ignored.
  - Arithmetic is modulo 2^WIDTH and wraps silently: all-ones+1 = 0, 0−1 = all-ones.
- tc is combinational: tc = en & (mode==11) & ((k[0]==0 & x==all-ones) | (k[0]==1 & x==0)). It is 0 in every other mode.
- y is purely combinational from x. There is no independent storage for y, so x and y can never both be 1, unlike a cross-coupled latch.
- Changing mode between edges is legal. The mode value sampled at the edge governs that edge, with no settling cycle.

## Timing
- Single-cycle latency: inputs sampled at rising edge N appear on x and y after edge N.
- tc and y follow x combinationally within the same cycle.
- sr_err asserts after the offending edge and stays asserted through any later edges until rst.
- Asynchronous reset assert takes effect without a clock. Deassert is synchronised externally; the block needs no recovery cycle.
- No handshakes. The block accepts an update on every enabled edge.

## Test plan
- Reset: run the COUNT state to 0x5A, assert rst between edges → x=0x00 and y=0xFF immediately, sr_err=0, tc=0; hold rst across 2 edges → no change.
- JK: x=0x00, mode=00, j=0xF0, k=0x0F → x=0xF0. Then j=k=0xFF → x=0x0F and sr_err=1. Then j=k=0x00 for 3 edges → x=0x0F and sr_err stays 1.
- D/T/en: mode=01, j=0xA5 → x=0xA5, y=0x5A. en=0, j=0x00 → x=0xA5. en=1, mode=10, j=0x0F → x=0xAA.
- Count up: mode=11, k[0]=0, x=0xFE → next x=0xFF with tc=1 → next x=0x00 with tc=0. With en=0 at x=0xFF → tc=0.
- Count down: k[0]=1, x=0x01 → x=0x00 with tc=1 → x=0xFF. Switch mode to 00 with j=k=0 → x holds 0xFF and tc=0.
- Async reset mid-update: assert rst 1 ns before the edge that would take x from 0xFF to 0x00 → x=0x00 from reset. Release rst → first edge increments to 0x01.
